// File: rtl/tsp_pkg.sv
// Shared types and sizes for the path-lock arbiter.
// Lane FSM encoding and mask/index typedefs.
package tsp_pkg;
   localparam int NPOS  = 64;
   localparam int NREQ  = 7;
   localparam int POS_W = 6;
   localparam int REQ_W = $clog2(NREQ);

   typedef logic [NPOS-1:0]  pos_mask_t;
   typedef logic [REQ_W-1:0] req_id_t;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } lane_state_t;
endpackage

// File: rtl/path_lock_arbiter_rr_pick.sv
// Stateless round-robin selector: first eligible lane
// at or after the pointer, wrapping N-1 -> 0.
module rr_pick #(
   parameter int N  = 7,
   parameter int IW = 3
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   int j;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!valid && eligible[j]) begin
            valid = 1'b1;
            idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/path_lock_arbiter.sv
// Grants exclusive locks on sets of path positions to
// requesting lanes, one grant per cycle, round-robin.
module path_lock_arbiter #(
   parameter int NREQ = 7,
   parameter int NPOS = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ-1:0][NPOS-1:0] req_mask,
   input  logic [NREQ-1:0]           rel,
   output logic [NREQ-1:0]           grant,
   output logic [NREQ-1:0]           busy,
   output logic [NPOS-1:0]           locked_mask,
   output logic [31:0]               conflict_cnt
);

   import tsp_pkg::*;

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   lane_state_t               state     [NREQ];
   lane_state_t               state_nxt [NREQ];
   logic [NREQ-1:0][NPOS-1:0] held;
   logic [NREQ-1:0][NPOS-1:0] held_nxt;
   logic [IW-1:0]             ptr;
   logic [IW-1:0]             ptr_nxt;
   logic [NREQ-1:0]           grant_nxt;
   logic [NREQ-1:0]           cand;
   logic [NREQ-1:0]           elig;
   logic [31:0]               cnt_nxt;
   logic                      pick_valid;
   logic [IW-1:0]             pick_idx;

   // Eligibility sees the pre-release mask, so freed
   // positions only become grantable a cycle later.
   always_comb begin
      locked_mask = '0;
      busy        = '0;
      cand        = '0;
      elig        = '0;
      for (int i = 0; i < NREQ; i++) begin
         locked_mask = locked_mask | held[i];
         busy[i]     = (state[i] == HOLD);
      end
      for (int i = 0; i < NREQ; i++) begin
         cand[i] = req_valid[i] & ~busy[i] & ~rel[i];
         elig[i] = cand[i] & ~|(req_mask[i] & locked_mask);
      end
   end

   rr_pick #(
      .N  (NREQ),
      .IW (IW)
   ) u_pick (
      .eligible (elig),
      .ptr      (ptr),
      .valid    (pick_valid),
      .idx      (pick_idx)
   );

   always_comb begin
      state_nxt = state;
      held_nxt  = held;
      grant_nxt = '0;
      ptr_nxt   = ptr;
      cnt_nxt   = conflict_cnt;
      for (int i = 0; i < NREQ; i++) begin
         unique case (state[i])
            IDLE: begin
               if (pick_valid && pick_idx == IW'(i)) begin
                  state_nxt[i] = HOLD;
                  held_nxt[i]  = req_mask[i];
                  grant_nxt[i] = 1'b1;
               end
            end
            HOLD: begin
               if (rel[i]) begin
                  state_nxt[i] = IDLE;
                  held_nxt[i]  = '0;
               end
            end
            default: state_nxt[i] = IDLE;
         endcase
      end
      if (pick_valid) begin
         if (pick_idx == IW'(NREQ - 1)) ptr_nxt = '0;
         else                           ptr_nxt = pick_idx + 1'b1;
      end
      if (|(cand & ~grant_nxt) && conflict_cnt != '1)
         cnt_nxt = conflict_cnt + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREQ; i++) state[i] <= IDLE;
         held         <= '0;
         grant        <= '0;
         ptr          <= '0;
         conflict_cnt <= '0;
      end else begin
         state        <= state_nxt;
         held         <= held_nxt;
         grant        <= grant_nxt;
         ptr          <= ptr_nxt;
         conflict_cnt <= cnt_nxt;
      end
   end

endmodule

// File: doc/path_lock_arbiter.md
PATH_LOCK_ARBITER -- requirements
Module: path_lock_arbiter

Interface
REQ-001 Parameter SHALL be: NREQ, 7, number of requesters (solver lanes).
REQ-002 Parameter SHALL be: NPOS, 64, number of path positions that can be locked.
REQ-003 Port SHALL be: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port SHALL be: rst  input  1  synchronous, active-high reset.
REQ-005 Port SHALL be: req_valid  input  NREQ  per-requester lock request.
REQ-006 Port SHALL be: req_mask  input  NREQ x NPOS  per-requester set of path positions to lock.
REQ-007 Port SHALL be: rel  input  NREQ  per-requester release pulse.
REQ-008 Port SHALL be: grant  output  NREQ  one-cycle grant pulse; at most one bit set.
REQ-009 Port SHALL be: busy  output  NREQ  requester currently holds a lock.
REQ-010 Port SHALL be: locked_mask  output  NPOS  OR of all held masks.
REQ-011 Port SHALL be: conflict_cnt  output  32  count of cycles with a denied request.

Function
REQ-012 Each requester SHALL have a two-state FSM:
  - IDLE -> HOLD on grant.
  - HOLD -> IDLE on rel.
REQ-013 Requester i SHALL be eligible in cycle k when all of the following hold:
  - req_valid[i]=1;
  - busy[i]=0;
  - rel[i]=0;
  - (req_mask[i] AND registered locked_mask)=0.
REQ-014 Among eligible requesters, the first at or after the round-robin pointer (wrapping NREQ-1 -> 0) SHALL win; at most one grant per cycle.
REQ-015 On a win by requester w at edge k, these SHALL take effect from cycle k+1:
  - grant[w]=1 for exactly one cycle;
  - busy[w]=1;
  - held mask of w = req_mask[w];
  - locked_mask includes that mask;
  - pointer = (w+1) mod NREQ.
REQ-016 With no winner, the pointer SHALL be unchanged.
REQ-017 Request latency SHALL be one cycle from an eligible request to grant.
REQ-018 A requester SHALL keep req_valid and req_mask stable until grant; the block samples them every cycle and does not latch them early.
REQ-019 rel[i] while busy[i]=1 SHALL clear busy[i] and remove its held mask from locked_mask at the next edge.
REQ-020 rel[i] while busy[i]=0 SHALL be ignored.
REQ-021 Releases and grants in the same cycle SHALL be conservative: eligibility is tested against the pre-release locked_mask, so freed positions become grantable one cycle later.
REQ-022 Simultaneous rel[i] and req_valid[i] on a busy requester SHALL perform the release only; the new request is considered from the next cycle.
REQ-023 req_mask=0 SHALL be granted normally: busy set, nothing locked.
REQ-024 Held masks of different requesters SHALL never overlap; locked_mask bit p=1 iff exactly one busy requester holds p.
REQ-025 Position wrap-around (e.g. windows {63,0,1}) SHALL be encoded by the requester in req_mask; the block applies no index arithmetic.
REQ-026 conflict_cnt SHALL increment by 1 in any cycle where a requester with req_valid=1, busy=0 and rel=0 is not granted. It saturates at 0xFFFFFFFF.

Reset
REQ-027 While rst=1 at an edge, all outputs SHALL be cleared:
  - grant=0, busy=0, locked_mask=0, conflict_cnt=0;
  - all held masks=0;
  - pointer=0.
REQ-028 Reset mid-operation SHALL drop all locks without requiring rel; inputs are ignored during reset.
REQ-029 The first grant SHALL be possible at the first edge after rst deasserts.

Structure
REQ-030 Package tsp_pkg SHALL hold:
  - NPOS=64, NREQ=7, POS_W=6;
  - typedef pos_mask_t (logic [NPOS-1:0]);
  - typedef req_id_t (logic [$clog2(NREQ)-1:0]).
REQ-031 Sub-module rr_pick SHALL implement the combinational round-robin first-eligible selector (inputs eligible vector and pointer; outputs valid and index).
REQ-032 All state SHALL reside in path_lock_arbiter; rr_pick is stateless.

Verification
REQ-033 Single request: after reset, req_valid[2]=1, mask=0x7 -> grant[2] pulses in cycle 1, busy[2]=1, locked_mask=0x7.
REQ-034 Conflict: req 0 holds 0x6; req 1 requests 0x3 -> no grant, conflict_cnt +1 per cycle. rel[0] at cycle k -> grant[1] at k+2 (conservative release).
REQ-035 Round-robin: reqs 0, 3 and 5 request disjoint masks continuously with pointer=0 -> grant order 0, 3, 5; pointer ends at 6.
REQ-036 Wrap: req 4 holds 0x8000000000000001 (positions 63 and 0); req 6 requests position 0 -> denied; req 6 requests position 62 -> granted.
REQ-037 Reset mid-hold: three busy requesters, assert rst one cycle -> busy=0, locked_mask=0, conflict_cnt=0, pointer=0; stray rel is ignored.
REQ-038 Invariant check every cycle: popcount(grant)<=1 and pairwise held-mask AND=0.
